// File: rtl/fft_result_unloader.sv
// Streams the N bins of the in-place FFT result RAM out over valid/ready, tagged with index and last.
// Optional FFT_UNLOAD_FFTSHIFT_EN: flip the address MSB so the zero-frequency bin is centred.
module fft_result_unloader #(
  parameter int N          = 8192,
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  output logic                  o_ram_rd_en,
  output logic [ADDR_WIDTH-1:0] o_ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] i_ram_rd_data,
  output logic                  o_m_valid,
  input  logic                  i_m_ready,
  output logic [DATA_WIDTH-1:0] o_m_data,
  output logic [ADDR_WIDTH-1:0] o_m_index,
  output logic                  o_m_last,
  output logic                  o_busy,
  output logic                  o_done
);

  // state    | meaning
  // S_IDLE   | waiting for start
  // S_STREAM | issuing reads while FIFO credit is available
  // S_DRAIN  | all reads issued, emptying FIFO and in-flight read
  // S_DONE   | one-cycle done pulse
  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN, S_DONE} state_t;

  localparam logic [ADDR_WIDTH:0] LP_LAST = (ADDR_WIDTH+1)'(N - 1);
`ifdef FFT_UNLOAD_FFTSHIFT_EN
  localparam logic [ADDR_WIDTH-1:0] LP_FLIP = ADDR_WIDTH'(N / 2);
`else
  localparam logic [ADDR_WIDTH-1:0] LP_FLIP = '0;
`endif

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH:0]   r_issue_cnt;
  logic                  r_inflight;
  logic [ADDR_WIDTH-1:0] r_inflight_addr;
  logic                  r_inflight_last;
  logic [DATA_WIDTH-1:0] r_fifo_data [2];
  logic [ADDR_WIDTH-1:0] r_fifo_idx  [2];
  logic [1:0]            r_fifo_last;
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  logic [1:0]            r_count;

  logic                  w_push;
  logic                  w_pop;
  logic                  w_rd_en;
  logic                  w_last_issue;
  logic [2:0]            w_credit;
  logic [1:0]            w_count_nxt;
  logic [ADDR_WIDTH-1:0] w_addr;

  assign w_push       = r_inflight;
  assign w_pop        = o_m_valid && i_m_ready;
  // A slot freed by this cycle's pop is reusable now, which sustains one bin per cycle.
  assign w_credit     = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_rd_en      = (r_state == S_STREAM) && (w_credit < 3'd2);
  assign w_last_issue = (r_issue_cnt == LP_LAST);
  assign w_count_nxt  = r_count + {1'b0, w_push} - {1'b0, w_pop};
  assign w_addr       = r_issue_cnt[ADDR_WIDTH-1:0] ^ LP_FLIP;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    case (r_state)
      S_IDLE:   if (i_start) w_state_nxt = S_STREAM;
      S_STREAM: begin
        o_busy = 1'b1;
        if (w_rd_en && w_last_issue) w_state_nxt = S_DRAIN;
      end
      S_DRAIN:  begin
        o_busy = 1'b1;
        if ((w_count_nxt == 2'd0) && !r_inflight) w_state_nxt = S_DONE;
      end
      S_DONE:   begin
        o_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_issue_cnt     <= '0;
      r_inflight      <= 1'b0;
      r_inflight_addr <= '0;
      r_inflight_last <= 1'b0;
    end else begin
      if (r_state == S_IDLE) r_issue_cnt <= '0;
      else if (w_rd_en)      r_issue_cnt <= r_issue_cnt + 1'b1;
      r_inflight      <= w_rd_en;
      r_inflight_addr <= w_addr;
      r_inflight_last <= w_last_issue;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fifo_data[0] <= '0;
      r_fifo_data[1] <= '0;
      r_fifo_idx[0]  <= '0;
      r_fifo_idx[1]  <= '0;
      r_fifo_last    <= '0;
      r_wr_ptr       <= 1'b0;
      r_rd_ptr       <= 1'b0;
      r_count        <= '0;
    end else begin
      if (w_push) begin
        r_fifo_data[r_wr_ptr] <= i_ram_rd_data;
        r_fifo_idx[r_wr_ptr]  <= r_inflight_addr;
        r_fifo_last[r_wr_ptr] <= r_inflight_last;
        r_wr_ptr              <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      r_count <= w_count_nxt;
    end
  end

  assign o_ram_rd_en   = w_rd_en;
  assign o_ram_rd_addr = w_addr;
  assign o_m_valid     = (r_count != 2'd0);
  assign o_m_data      = r_fifo_data[r_rd_ptr];
  assign o_m_index     = r_fifo_idx[r_rd_ptr];
  assign o_m_last      = o_m_valid && r_fifo_last[r_rd_ptr];

  ap_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(w_push && !w_pop && (r_count == 2'd2)));

endmodule
